// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module mdu_div #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  div_valid_i,
    output logic                  div_ready_o,
    input  logic [1:0]            div_op_i,
    input  logic [DATA_WIDTH-1:0] div_src1_i,
    input  logic [DATA_WIDTH-1:0] div_src2_i,
    input  logic                  div_flush_i,
    output logic                  div_done_o,
    output logic [DATA_WIDTH-1:0] div_result_o
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);
    localparam logic [W-1:0]     MIN_NEG   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W:0]       r_rem;
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_divisor;
    logic             r_isRem;
    logic             r_negQ;
    logic             r_negR;
    logic [W-1:0]     r_result;

    logic         w_isSigned;
    logic         w_src1Neg;
    logic         w_src2Neg;
    logic [W-1:0] w_mag1;
    logic [W-1:0] w_mag2;
    logic         w_divByZero;
    logic         w_overflow;
    logic [W-1:0] w_fastResult;
    logic         w_accept;
    logic [W+1:0] w_diff;
    logic         w_borrow;
    logic [W:0]   w_remNext;
    logic [W-1:0] w_quoNext;
    logic [W-1:0] w_quoFinal;
    logic [W-1:0] w_remFinal;
    logic [W-1:0] w_calcResult;

    assign w_isSigned  = ~div_op_i[0];
    assign w_src1Neg   = w_isSigned & div_src1_i[W-1];
    assign w_src2Neg   = w_isSigned & div_src2_i[W-1];
    assign w_mag1      = w_src1Neg ? -div_src1_i : div_src1_i;
    assign w_mag2      = w_src2Neg ? -div_src2_i : div_src2_i;
    assign w_divByZero = (div_src2_i == '0);
    assign w_overflow  = w_isSigned & (div_src1_i == MIN_NEG) & (div_src2_i == '1);
    assign w_accept    = div_valid_i & (r_state == IDLE) & ~div_flush_i;

    always_comb begin
        w_fastResult = '0;
        if (w_divByZero) begin
            w_fastResult = div_op_i[1] ? div_src1_i : '1;
        end else if (w_overflow) begin
            w_fastResult = div_op_i[1] ? '0 : MIN_NEG;
        end
    end

    // The remainder is at most divisor-1, so r_rem[W] is always zero here;
    // the extra top bit of the difference is the borrow.
    assign w_diff     = {r_rem, r_quo[W-1]} - {2'b00, r_divisor};
    assign w_borrow   = w_diff[W+1];
    assign w_remNext  = w_borrow ? {r_rem[W-1:0], r_quo[W-1]} : w_diff[W:0];
    assign w_quoNext  = {r_quo[W-2:0], ~w_borrow};

    assign w_quoFinal   = r_negQ ? -w_quoNext : w_quoNext;
    assign w_remFinal   = r_negR ? -w_remNext[W-1:0] : w_remNext[W-1:0];
    assign w_calcResult = r_isRem ? w_remFinal : w_quoFinal;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_isRem   <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_isRem   <= div_op_i[1];
                        r_negQ    <= w_src1Neg ^ w_src2Neg;
                        r_negR    <= w_src1Neg;
                        r_divisor <= w_mag2;
                        r_quo     <= w_mag1;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        if (w_divByZero || w_overflow) begin
                            r_result <= w_fastResult;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (div_flush_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_rem <= w_remNext;
                        r_quo <= w_quoNext;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_STEP) begin
                            r_result <= w_calcResult;
                            r_state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign div_ready_o  = (r_state == IDLE);
    assign div_done_o   = (r_state == DONE) & ~div_flush_i;
    assign div_result_o = r_result;

endmodule

// File: tb/tb_mdu_div.sv
// Directed testbench for mdu_div: hand-computed RV32M results, latency,
// flush, mid-operation reset and back-to-back issue.
module tb_mdu_div;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [1:0]  divOp;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        done;
    logic [31:0] result;

    int vectors;
    int miscompares;

    mdu_div #(.DATA_WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .div_valid_i (valid),
        .div_ready_o (ready),
        .div_op_i    (divOp),
        .div_src1_i  (src1),
        .div_src2_i  (src2),
        .div_flush_i (flush),
        .div_done_o  (done),
        .div_result_o(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and watches it until the unit is idle again.
    // lat is the cycle (1 = first cycle after accept) in which done was seen.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output int readyLow);
        divOp = op;
        src1  = a;
        src2  = b;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid    = 1'b0;
        lat      = 0;
        res      = 32'h0;
        readyLow = 0;
        for (int c = 1; c <= 100; c++) begin
            if (!ready) readyLow++;
            if (done && lat == 0) begin
                lat = c;
                res = result;
            end
            if (ready) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready got=%b want=1", ready);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_done got=%b want=0", done);
        end
        vectors++;
        if (result !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_result got=%h want=00000000", result);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_divu();
        int lat;
        int rl;
        logic [31:0] res;
        runOp(2'b01, 32'd100, 32'd7, lat, res, rl);
        vectors++;
        if (res !== 32'h0000000E) begin
            miscompares++;
            $display("[TB] FAIL divu_100_7 got=%h want=0000000e", res);
        end
        vectors++;
        if (lat !== 33) begin
            miscompares++;
            $display("[TB] FAIL divu_latency got=%0d want=33", lat);
        end
        runOp(2'b11, 32'd100, 32'd7, lat, res, rl);
        vectors++;
        if (res !== 32'h00000002) begin
            miscompares++;
            $display("[TB] FAIL remu_100_7 got=%h want=00000002", res);
        end
        vectors++;
        if (rl !== 33) begin
            miscompares++;
            $display("[TB] FAIL remu_busy_cycles got=%0d want=33", rl);
        end
    endtask

    task automatic test_signed();
        int lat;
        int rl;
        logic [31:0] res;
        runOp(2'b00, 32'hFFFFFFF9, 32'h2, lat, res, rl);
        vectors++;
        if (res !== 32'hFFFFFFFD) begin
            miscompares++;
            $display("[TB] FAIL div_m7_2 got=%h want=fffffffd", res);
        end
        runOp(2'b10, 32'hFFFFFFF9, 32'h2, lat, res, rl);
        vectors++;
        if (res !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("[TB] FAIL rem_m7_2 got=%h want=ffffffff", res);
        end
        runOp(2'b10, 32'h7, 32'hFFFFFFFE, lat, res, rl);
        vectors++;
        if (res !== 32'h00000001) begin
            miscompares++;
            $display("[TB] FAIL rem_7_m2 got=%h want=00000001", res);
        end
        runOp(2'b00, 32'h7, 32'hFFFFFFFE, lat, res, rl);
        vectors++;
        if (res !== 32'hFFFFFFFD) begin
            miscompares++;
            $display("[TB] FAIL div_7_m2 got=%h want=fffffffd", res);
        end
        runOp(2'b10, 32'hFFFFFFFC, 32'h2, lat, res, rl);
        vectors++;
        if (res !== 32'h00000000) begin
            miscompares++;
            $display("[TB] FAIL rem_neg_zero got=%h want=00000000", res);
        end
        runOp(2'b01, 32'hFFFFFFF9, 32'h2, lat, res, rl);
        vectors++;
        if (res !== 32'h7FFFFFFC) begin
            miscompares++;
            $display("[TB] FAIL divu_big got=%h want=7ffffffc", res);
        end
    endtask

    task automatic test_overflow();
        int lat;
        int rl;
        logic [31:0] res;
        runOp(2'b00, 32'h80000000, 32'hFFFFFFFF, lat, res, rl);
        vectors++;
        if (res !== 32'h80000000) begin
            miscompares++;
            $display("[TB] FAIL div_overflow got=%h want=80000000", res);
        end
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("[TB] FAIL div_overflow_latency got=%0d want=1", lat);
        end
        runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, res, rl);
        vectors++;
        if (res !== 32'h00000000) begin
            miscompares++;
            $display("[TB] FAIL rem_overflow got=%h want=00000000", res);
        end
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("[TB] FAIL rem_overflow_latency got=%0d want=1", lat);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        int rl;
        logic [31:0] res;
        runOp(2'b01, 32'h8FFFFF00, 32'h0, lat, res, rl);
        vectors++;
        if (res !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("[TB] FAIL divu_by_zero got=%h want=ffffffff", res);
        end
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("[TB] FAIL divu_by_zero_latency got=%0d want=1", lat);
        end
        vectors++;
        if (rl !== 1) begin
            miscompares++;
            $display("[TB] FAIL divu_by_zero_busy got=%0d want=1", rl);
        end
        runOp(2'b00, 32'h12345678, 32'h0, lat, res, rl);
        vectors++;
        if (res !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("[TB] FAIL div_by_zero got=%h want=ffffffff", res);
        end
        runOp(2'b11, 32'h8FFFFF00, 32'h0, lat, res, rl);
        vectors++;
        if (res !== 32'h8FFFFF00) begin
            miscompares++;
            $display("[TB] FAIL remu_by_zero got=%h want=8fffff00", res);
        end
        vectors++;
        if (rl !== 1) begin
            miscompares++;
            $display("[TB] FAIL remu_by_zero_busy got=%0d want=1", rl);
        end
    endtask

    task automatic test_flush();
        int lat;
        int rl;
        int sawDone;
        logic [31:0] res;
        divOp = 2'b01;
        src1  = 32'd1000;
        src2  = 32'd3;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_ready got=%b want=1", ready);
        end
        vectors++;
        if (result !== 32'h8FFFFF00) begin
            miscompares++;
            $display("[TB] FAIL flush_result_held got=%h want=8fffff00", result);
        end
        sawDone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) sawDone++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (sawDone !== 0) begin
            miscompares++;
            $display("[TB] FAIL flush_no_done got=%0d pulses want=0", sawDone);
        end
        runOp(2'b01, 32'hFFFFFFFF, 32'h10, lat, res, rl);
        vectors++;
        if (res !== 32'h0FFFFFFF) begin
            miscompares++;
            $display("[TB] FAIL after_flush_divu got=%h want=0fffffff", res);
        end
        vectors++;
        if (lat !== 33) begin
            miscompares++;
            $display("[TB] FAIL after_flush_latency got=%0d want=33", lat);
        end
    endtask

    task automatic test_reset_mid();
        divOp = 2'b00;
        src1  = 32'd5000;
        src2  = 32'd7;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_ready got=%b want=1", ready);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_done got=%b want=0", done);
        end
        vectors++;
        if (result !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_result got=%h want=00000000", result);
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        int gap;
        logic [31:0] res1;
        logic [31:0] res2;
        lat1 = 0;
        lat2 = 0;
        gap  = 0;
        res1 = 32'h0;
        res2 = 32'h0;
        divOp = 2'b01;
        src1  = 32'd100;
        src2  = 32'd7;
        valid = 1'b1;
        @(posedge clk);
        #1;
        src1 = 32'd200;
        src2 = 32'd9;
        for (int c = 1; c <= 100; c++) begin
            if (done && lat1 == 0) begin
                lat1 = c;
                res1 = result;
            end
            if (ready) begin
                gap = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                lat2 = c;
                res2 = result;
                break;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (res1 !== 32'h0000000E) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_result got=%h want=0000000e", res1);
        end
        vectors++;
        if (lat1 !== 33) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_latency got=%0d want=33", lat1);
        end
        vectors++;
        if (gap !== 34) begin
            miscompares++;
            $display("[TB] FAIL b2b_issue_gap got=%0d want=34", gap);
        end
        vectors++;
        if (res2 !== 32'h00000016) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_result got=%h want=00000016", res2);
        end
        vectors++;
        if (lat2 !== 33) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_latency got=%0d want=33", lat2);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        valid = 1'b0;
        flush = 1'b0;
        divOp = 2'b00;
        src1  = 32'h0;
        src2  = 32'h0;
        test_reset();
        test_divu();
        test_signed();
        test_overflow();
        test_div_zero();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
